q2fsm_ctx_sched: RTL and testbench

Time-multiplexed scheduler that shares a single six-state w-sequence detector (states A–F, z asserted in E/F) among N independent input channels. Each channel's detector state is held as a saved context. A round-robin arbiter grants one pending sample per cycle, and the shared next-state logic advances that channel's context. The block sits between per-channel serial w sources and downstream match consumers, replacing N copies of the detector.

---
 rtl/q2fsm_pkg.sv | 35 +++
 rtl/q2fsm_rr_arb.sv | 51 +++++
 rtl/q2fsm_ctx_sched.sv | 93 +++++++++
 tb/tb_q2fsm_ctx_sched.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/q2fsm_pkg.sv
// Shared types and combinational helpers for the time-multiplexed w-sequence detector.
package q2fsm_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_A = 3'd0,
    ST_B = 3'd1,
    ST_C = 3'd2,
    ST_D = 3'd3,
    ST_E = 3'd4,
    ST_F = 3'd5
  } state_e;

  // Codes 6 and 7 fall to A so a corrupted context recovers on its next sample.
  function automatic state_e next_state(input logic [STATE_W-1:0] s, input logic w);
    state_e n;
    n = ST_A;
    case (s)
      ST_A:    n = w ? ST_B : ST_A;
      ST_B:    n = w ? ST_C : ST_D;
      ST_C:    n = w ? ST_E : ST_D;
      ST_D:    n = w ? ST_F : ST_A;
      ST_E:    n = w ? ST_E : ST_D;
      ST_F:    n = w ? ST_C : ST_D;
      default: n = ST_A;
    endcase
    return n;
  endfunction

  function automatic logic is_match(input logic [STATE_W-1:0] s);
    return (s == ST_E) || (s == ST_F);
  endfunction

endpackage

// File: rtl/q2fsm_rr_arb.sv
// N-way round-robin arbiter; pointer moves one past the winner only when advance is high.
module q2fsm_rr_arb #(
  parameter int unsigned N = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);

  localparam int unsigned IDX_W = $clog2(N);
  localparam int unsigned SUM_W = IDX_W + 1;
  localparam logic [SUM_W-1:0] N_SUM = SUM_W'(N);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic [SUM_W-1:0] cand_sum;
  logic [SUM_W-1:0] inc_sum;
  logic             found;

  // First requester at or after the pointer, wrapping modulo N.
  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    found    = 1'b0;
    cand_sum = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand_sum = {1'b0, ptr_q} + SUM_W'(k);
      if (cand_sum >= N_SUM) cand_sum = cand_sum - N_SUM;
      if (!found && req[cand_sum[IDX_W-1:0]]) begin
        found                      = 1'b1;
        gnt[cand_sum[IDX_W-1:0]]   = 1'b1;
        gnt_idx                    = cand_sum[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    ptr_d   = ptr_q;
    inc_sum = {1'b0, gnt_idx} + SUM_W'(1);
    if (advance) ptr_d = (inc_sum == N_SUM) ? '0 : inc_sum[IDX_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/q2fsm_ctx_sched.sv
// Shares one six-state w-sequence detector among N channels by saving per-channel contexts
// and advancing one granted channel per cycle.
module q2fsm_ctx_sched
  import q2fsm_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         in_valid,
  input  logic [N-1:0]         in_w,
  output logic [N-1:0]         in_ready,
  input  logic [N-1:0]         flush,
  output logic                 out_valid,
  output logic [$clog2(N)-1:0] out_chan,
  output logic                 out_z,
  output logic [N-1:0]         z_vec
);

  localparam int unsigned IDX_W = $clog2(N);

  state_e           ctx_q [N];
  state_e           ctx_d [N];
  logic [N-1:0]     req;
  logic [N-1:0]     gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             grant_any;
  state_e           sel_nxt;

  logic             out_valid_q, out_valid_d;
  logic [IDX_W-1:0] out_chan_q, out_chan_d;
  logic             out_z_q, out_z_d;
  logic [N-1:0]     z_vec_q, z_vec_d;

  // Flush beats a grant on the same channel; reset blocks every grant.
  assign req       = in_valid & ~flush & {N{~reset}};
  assign grant_any = |gnt;
  assign in_ready  = gnt;

  q2fsm_rr_arb #(.N(N)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .advance (grant_any),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_comb sel_nxt = next_state(ctx_q[gnt_idx], in_w[gnt_idx]);

  always_comb begin
    for (int i = 0; i < N; i++) begin
      ctx_d[i] = ctx_q[i];
      if (flush[i])    ctx_d[i] = ST_A;
      else if (gnt[i]) ctx_d[i] = sel_nxt;
    end
  end

  // z_vec is registered from the next contexts so it lines up with out_*.
  always_comb begin
    z_vec_d     = '0;
    out_valid_d = grant_any;
    out_chan_d  = out_chan_q;
    out_z_d     = out_z_q;
    if (grant_any) begin
      out_chan_d = gnt_idx;
      out_z_d    = is_match(sel_nxt);
    end
    for (int i = 0; i < N; i++) z_vec_d[i] = is_match(ctx_d[i]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) ctx_q[i] <= ST_A;
      out_valid_q <= 1'b0;
      out_chan_q  <= '0;
      out_z_q     <= 1'b0;
      z_vec_q     <= '0;
    end else begin
      for (int i = 0; i < N; i++) ctx_q[i] <= ctx_d[i];
      out_valid_q <= out_valid_d;
      out_chan_q  <= out_chan_d;
      out_z_q     <= out_z_d;
      z_vec_q     <= z_vec_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_chan  = out_chan_q;
  assign out_z     = out_z_q;
  assign z_vec     = z_vec_q;

endmodule

// File: tb/tb_q2fsm_ctx_sched.sv
// Directed and randomized checks of q2fsm_ctx_sched against a table-driven channel model.
module tb_q2fsm_ctx_sched;

  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  in_valid = '0;
  logic [N-1:0]  in_w = '0;
  logic [N-1:0]  flush = '0;
  logic [N-1:0]  in_ready;
  logic          out_valid;
  logic [IW-1:0] out_chan;
  logic          out_z;
  logic [N-1:0]  z_vec;

  int checks = 0;
  int errors = 0;

  // Reference model: detector transitions as lookup tables, state numbers A=0..F=5.
  int tbl0 [6] = '{0, 3, 3, 0, 3, 3};
  int tbl1 [6] = '{1, 2, 4, 5, 4, 2};
  int m_ctx [N];
  int m_ptr = 0;
  int m_ov = 0;
  int m_oc = 0;
  int m_oz = 0;
  int last_g = -1;
  bit hold_valid = 1'b0;

  bit sw [5] = '{1, 1, 1, 0, 1};
  bit sz [5] = '{0, 0, 1, 0, 1};
  bit s1 [3] = '{1, 0, 1};
  bit s2 [3] = '{1, 1, 0};

  q2fsm_ctx_sched #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_w      (in_w),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_chan  (out_chan),
    .out_z     (out_z),
    .z_vec     (z_vec)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: check the grant before the edge, advance the model, check outputs after.
  task automatic cycle();
    int g;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] exp_zv;
    logic [N-1:0] f_s;
    logic r_s;
    @(negedge clk);
    g = -1;
    if (!reset) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (g < 0 && in_valid[c] && !flush[c]) g = c;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    f_s = flush;
    r_s = reset;
    @(posedge clk);
    #1;
    if (r_s) begin
      for (int i = 0; i < N; i++) m_ctx[i] = 0;
      m_ptr = 0; m_ov = 0; m_oc = 0; m_oz = 0;
    end else begin
      if (g >= 0) begin
        m_ctx[g] = in_w[g] ? tbl1[m_ctx[g]] : tbl0[m_ctx[g]];
        m_ptr = (g + 1) % N;
        m_ov = 1;
        m_oc = g;
        m_oz = (m_ctx[g] >= 4) ? 1 : 0;
        if (!hold_valid) in_valid[g] = 1'b0;
      end else begin
        m_ov = 0;
      end
      for (int i = 0; i < N; i++) if (f_s[i]) m_ctx[i] = 0;
    end
    last_g = g;
    exp_zv = '0;
    for (int i = 0; i < N; i++) exp_zv[i] = (m_ctx[i] >= 4);
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("out_chan", 32'(out_chan), 32'(m_oc));
    chk("out_z", 32'(out_z), 32'(m_oz));
    chk("z_vec", 32'(z_vec), 32'(exp_zv));
  endtask

  task automatic send(input int ch, input logic w);
    in_valid[ch] = 1'b1;
    in_w[ch] = w;
    for (int t = 0; t < 2 * N && in_valid[ch]; t++) cycle();
  endtask

  task automatic do_reset();
    in_valid = '0;
    flush = '0;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) m_ctx[i] = 0;

    // Reset then idle.
    cycle();
    do_reset();
    repeat (5) cycle();

    // Channel 0 alone: B, C, E, D, F.
    for (int i = 0; i < 5; i++) begin
      in_valid[0] = 1'b1;
      in_w[0] = sw[i];
      cycle();
      chk("ch0_seq_z", 32'(out_z), 32'(sz[i]));
      if (i == 2) chk("ch0_zvec", 32'(z_vec[0]), 32'd1);
    end

    // All channels continuously valid: strict rotation from channel 0.
    do_reset();
    hold_valid = 1'b1;
    in_w = N'($urandom);
    in_valid = '1;
    for (int i = 0; i < 12; i++) begin
      cycle();
      chk("rr_order", 32'(out_chan), 32'(i % N));
      in_w[last_g] = 1'($urandom);
    end
    hold_valid = 1'b0;
    in_valid = '0;

    // Interleaved channels 1 and 2.
    do_reset();
    for (int s = 0; s < 3; s++) begin
      in_valid[1] = 1'b1; in_w[1] = s1[s];
      in_valid[2] = 1'b1; in_w[2] = s2[s];
      cycle();
      if (s == 2) chk("ilv_ch1_z", 32'(out_z), 32'd1);
      cycle();
    end
    chk("ilv_last_chan", 32'(out_chan), 32'd2);
    chk("ilv_ch2_z", 32'(out_z), 32'd0);
    chk("ilv_zvec1", 32'(z_vec[1]), 32'd1);
    chk("ilv_zvec2", 32'(z_vec[2]), 32'd0);

    // Flush of channel 2 at ptr=2 hands the grant to channel 3.
    do_reset();
    send(2, 1'b1);
    send(2, 1'b1);
    send(1, 1'b1);
    in_valid[2] = 1'b1; in_w[2] = 1'b1; flush[2] = 1'b1;
    in_valid[3] = 1'b1; in_w[3] = 1'b0;
    cycle();
    chk("flush_alt_chan", 32'(out_chan), 32'd3);
    flush = '0;
    cycle();
    chk("flush_ch2_chan", 32'(out_chan), 32'd2);
    chk("flush_ch2_z", 32'(out_z), 32'd0);

    // Reset mid-stream with a channel 1 sample pending in state E.
    do_reset();
    send(1, 1'b1);
    send(1, 1'b1);
    send(1, 1'b1);
    chk("mid_zvec_e", 32'(z_vec[1]), 32'd1);
    in_valid[1] = 1'b1; in_w[1] = 1'b0;
    reset = 1'b1;
    cycle();
    chk("mid_out_valid", 32'(out_valid), 32'd0);
    chk("mid_zvec_clr", 32'(z_vec), 32'd0);
    reset = 1'b0;
    in_valid = '1;
    cycle();
    chk("mid_ptr_zero", 32'(out_chan), 32'd0);
    in_valid = '0;

    // Randomized traffic with flushes and occasional resets.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!in_valid[i] && $urandom_range(1, 0) == 1) begin
          in_valid[i] = 1'b1;
          in_w[i] = 1'($urandom_range(1, 0));
        end
        flush[i] = ($urandom_range(7, 0) == 0);
      end
      reset = ($urandom_range(63, 0) == 0);
      cycle();
    end
    reset = 1'b0;
    flush = '0;
    in_valid = '0;
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
